// File: rtl/dlx_mem_pkg.sv
// Shared encodings for the data-memory access path: access sizes and the bus master FSM states.
package dlx_mem_pkg;

    localparam logic [1:0] DSIZE_BYTE = 2'b00;
    localparam logic [1:0] DSIZE_HALF = 2'b01;
    localparam logic [1:0] DSIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } dmemState_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Big-endian byte-lane steering: access size and low address bits to byte enables,
// replicated store data and a misalignment flag.
module dmem_lane_align
    import dlx_mem_pkg::*;
(
    input  logic [1:0]  DSize_in,
    input  logic [0:1]  addrLow,
    input  logic [0:31] opB_in,
    output logic [0:3]  be,
    output logic [0:31] wdata,
    output logic        misaligned
);

    always_comb begin
        be         = 4'b1111;
        wdata      = opB_in;
        misaligned = 1'b0;
        case (DSize_in)
            DSIZE_BYTE: begin
                // be[0] is the most significant lane, so lane k is the k-th bit from the left
                be    = 4'b1000 >> addrLow;
                wdata = {4{opB_in[24:31]}};
            end
            DSIZE_HALF: begin
                be         = addrLow[0] ? 4'b0011 : 4'b1100;
                wdata      = {2{opB_in[16:31]}};
                misaligned = addrLow[1];
            end
            default: begin
                misaligned = |addrLow;
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Data-memory bus master for the MEM stage: issues one req/ack transaction per access,
// stalls the pipeline meanwhile, and reports misaligned accesses and bus timeouts.
module dmem_access_unit
    import dlx_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:31] aluResult_in,
    input  logic [0:31] opB_in,
    input  logic        MemWrite_in,
    input  logic        MemToReg_in,
    input  logic [1:0]  DSize_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [0:31] dmem_addr,
    output logic [0:3]  dmem_be,
    output logic [0:31] dmem_wdata,
    input  logic [0:31] dmem_rdata,
    input  logic        dmem_ack,
    output logic [0:31] dMemValue_out,
    output logic        stall_out,
    output logic        misalign_out,
    output logic        buserr_out,
    output dmemState_t  dbgState
);

    // Bus handshake: dmem_req rises with we/addr/be/wdata already stable and stays high,
    // with those fields frozen, until the cycle in which dmem_ack is seen high. dmem_ack is a
    // single-cycle strobe carrying dmem_rdata; an ack seen while dmem_req is low is ignored.

    dmemState_t      state, nextState;
    logic [TO_W-1:0] counter;
    logic            access, misaligned, timeoutHit;
    logic [0:3]      alignBe;
    logic [0:31]     alignWdata;

    dmem_lane_align u_align (
        .DSize_in   (DSize_in),
        .addrLow    (aluResult_in[30:31]),
        .opB_in     (opB_in),
        .be         (alignBe),
        .wdata      (alignWdata),
        .misaligned (misaligned)
    );

    assign access     = MemWrite_in | MemToReg_in;
    assign timeoutHit = (counter == TO_W'(TIMEOUT_CYCLES - 1));
    assign dmem_req   = (state == REQ);
    assign dbgState   = state;

    always_comb begin
        nextState = state;
        stall_out = 1'b0;
        case (state)
            IDLE: begin
                stall_out = access;
                if (access) nextState = misaligned ? DONE : REQ;
            end
            REQ: begin
                stall_out = 1'b1;
                if (dmem_ack || timeoutHit) nextState = DONE;
            end
            default: nextState = IDLE;
        endcase
        // The pipeline must be free to flush while reset is held
        if (reset) stall_out = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            counter       <= '0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_be       <= '0;
            dmem_wdata    <= '0;
            dMemValue_out <= '0;
            misalign_out  <= 1'b0;
            buserr_out    <= 1'b0;
        end else begin
            state        <= nextState;
            misalign_out <= 1'b0;
            buserr_out   <= 1'b0;
            case (state)
                IDLE: begin
                    if (access && misaligned) begin
                        misalign_out  <= 1'b1;
                        dMemValue_out <= '0;
                    end else if (access) begin
                        dmem_addr  <= {aluResult_in[0:29], 2'b00};
                        dmem_we    <= MemWrite_in;
                        dmem_be    <= alignBe;
                        dmem_wdata <= alignWdata;
                        counter    <= '0;
                    end
                end
                REQ: begin
                    counter <= counter + 1'b1;
                    // An ack arriving on the timeout cycle still wins
                    if (dmem_ack) begin
                        dMemValue_out <= dmem_we ? '0 : dmem_rdata;
                    end else if (timeoutHit) begin
                        buserr_out    <= 1'b1;
                        dMemValue_out <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
